tap_tempo: RTL and testbench

- Sits directly downstream of the footswitch edge detector.
- Consumes its one-cycle tap pulses and measures the interval between successive taps in audio sample periods.
- Publishes the result as the delay length used by the delay-line address generator.
- Filters switch bounce with a lockout window, averages consecutive intervals, and abandons a tap sequence after a timeout.

---
 rtl/tap_tempo.sv | 97 +++++++++
 tb/tb_tap_tempo.sv | 128 ++++++++++++
 2 files changed

// File: rtl/tap_tempo.sv
// tap_tempo: measures the interval between footswitch taps in audio sample
// periods and publishes it as the delay-line length.
//   clk         system clock
//   nrst        asynchronous active-low reset
//   tap         one-cycle tap pulse from the edge detector
//   sample_tick one-cycle strobe per audio sample period
//   delay_len   current delay length in samples (LEN_W bits)
//   len_valid   one-cycle pulse after delay_len is updated
//   tapping     high while a tap sequence is in progress
module tap_tempo #(
    parameter int LEN_W       = 16,
    parameter int MIN_LEN     = 480,
    parameter int MAX_LEN     = 65535,
    parameter int DEFAULT_LEN = 24000
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             tap,
    input  logic             sample_tick,
    output logic [LEN_W-1:0] delay_len,
    output logic             len_valid,
    output logic             tapping
);
    typedef enum logic {IDLE, COUNT} state_t;

    localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] DEF_L = LEN_W'(DEFAULT_LEN);

    state_t           state, state_nxt;
    logic [LEN_W-1:0] cnt, cnt_nxt;
    logic [LEN_W-1:0] prev, prev_nxt;
    logic             have_prev, have_prev_nxt;
    logic [LEN_W-1:0] len_nxt;
    logic             valid_nxt;
    logic [LEN_W:0]   sum;

    // One extra bit so the two-interval average cannot overflow.
    assign sum = {1'b0, prev} + {1'b0, cnt};

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        prev_nxt      = prev;
        have_prev_nxt = have_prev;
        len_nxt       = delay_len;
        valid_nxt     = 1'b0;
        case (state)
            IDLE: begin
                if (tap) begin
                    state_nxt     = COUNT;
                    cnt_nxt       = '0;
                    have_prev_nxt = 1'b0;
                end
            end
            COUNT: begin
                if (tap && cnt >= MIN_L) begin
                    // Accepted tap wins over a coincident tick, including
                    // the timeout tick at cnt == MAX_LEN.
                    len_nxt       = have_prev ? sum[LEN_W:1] : cnt;
                    prev_nxt      = cnt;
                    have_prev_nxt = 1'b1;
                    cnt_nxt       = '0;
                    valid_nxt     = 1'b1;
                end else if (sample_tick && cnt == MAX_L) begin
                    // Sequence abandoned; keep the last published length.
                    state_nxt     = IDLE;
                    have_prev_nxt = 1'b0;
                end else if (sample_tick) begin
                    // Bounce taps (cnt < MIN_LEN) land here and are ignored.
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state     <= IDLE;
            cnt       <= '0;
            prev      <= '0;
            have_prev <= 1'b0;
            delay_len <= DEF_L;
            len_valid <= 1'b0;
            tapping   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            prev      <= prev_nxt;
            have_prev <= have_prev_nxt;
            delay_len <= len_nxt;
            len_valid <= valid_nxt;
            tapping   <= (state_nxt == COUNT);
        end
    end
endmodule

// File: tb/tb_tap_tempo.sv
module tb_tap_tempo;
    logic        clk = 1'b0;
    logic        clk_en = 1'b0;
    logic        nrst = 1'b1;
    logic [1:0]  tap_v = '0;
    logic [1:0]  tick_v = '0;
    logic [15:0] dl [2];
    logic        lv [2];
    logic        tp [2];
    int          tests = 0;
    int          fails = 0;

    // Unit 0: default parameters. Unit 1: short timeout configuration.
    tap_tempo dut0 (
        .clk(clk), .nrst(nrst), .tap(tap_v[0]), .sample_tick(tick_v[0]),
        .delay_len(dl[0]), .len_valid(lv[0]), .tapping(tp[0])
    );
    tap_tempo #(.LEN_W(16), .MIN_LEN(50), .MAX_LEN(1000), .DEFAULT_LEN(500)) dut1 (
        .clk(clk), .nrst(nrst), .tap(tap_v[1]), .sample_tick(tick_v[1]),
        .delay_len(dl[1]), .len_valid(lv[1]), .tapping(tp[1])
    );

    initial begin
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    typedef struct {
        int u;        // which unit
        int ticks;    // tick-only cycles applied first
        bit tp;       // tap on the final cycle
        bit tk;       // tick on the final cycle
        int exp_len;
        bit exp_v;
        bit exp_t;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_step(input vec_t v, input int idx);
        int stray;
        stray = 0;
        for (int i = 0; i < v.ticks; i++) begin
            @(negedge clk);
            tick_v[v.u] = 1'b1;
            @(posedge clk);
            #1;
            if (lv[v.u] !== 1'b0) stray++;
        end
        @(negedge clk);
        tap_v[v.u]  = v.tp;
        tick_v[v.u] = v.tk;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d no valid while counting", idx), stray, 0);
        chk($sformatf("v%0d delay_len", idx), 32'(dl[v.u]), v.exp_len);
        chk($sformatf("v%0d len_valid", idx), 32'(lv[v.u]), 32'(v.exp_v));
        chk($sformatf("v%0d tapping", idx), 32'(tp[v.u]), 32'(v.exp_t));
        @(negedge clk);
        tap_v  = '0;
        tick_v = '0;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d len_valid one cycle", idx), 32'(lv[v.u]), 0);
    endtask

    initial begin
        // Reset with no clock running.
        #2 nrst = 1'b0;
        #1;
        chk("reset delay_len", 32'(dl[0]), 24000);
        chk("reset len_valid", 32'(lv[0]), 0);
        chk("reset tapping", 32'(tp[0]), 0);
        chk("reset delay_len unit1", 32'(dl[1]), 500);
        #4 nrst = 1'b1;
        #4 clk_en = 1'b1;

        // unit 0: first tap, bounce tap+tick at cnt 100, accept at 12000, average
        vecs.push_back('{0, 0,     1, 0, 24000, 0, 1});
        vecs.push_back('{0, 100,   1, 1, 24000, 0, 1});
        vecs.push_back('{0, 11899, 1, 0, 12000, 1, 1});
        vecs.push_back('{0, 13001, 1, 0, 12500, 1, 1});
        // unit 1: measure, time out, restart without averaging old prev
        vecs.push_back('{1, 0,    1, 0, 500,  0, 1});
        vecs.push_back('{1, 600,  1, 0, 600,  1, 1});
        vecs.push_back('{1, 1001, 0, 0, 600,  0, 0});
        vecs.push_back('{1, 0,    1, 0, 600,  0, 1});
        vecs.push_back('{1, 700,  1, 1, 700,  1, 1});   // tap+tick, tick consumed
        vecs.push_back('{1, 601,  1, 0, 650,  1, 1});   // (700+601)>>1
        vecs.push_back('{1, 10,   1, 0, 650,  0, 1});   // bounce
        vecs.push_back('{1, 990,  1, 1, 800,  1, 1});   // tap at MAX with tick: (601+1000)>>1
        vecs.push_back('{1, 1001, 0, 0, 800,  0, 0});   // timeout
        vecs.push_back('{1, 0,    1, 0, 800,  0, 1});
        vecs.push_back('{1, 1000, 1, 1, 1000, 1, 1});   // first of fresh sequence at MAX

        foreach (vecs[i]) run_step(vecs[i], i);

        // Asynchronous reset in the middle of a sequence (unit 0 is counting).
        @(negedge clk);
        #1 nrst = 1'b0;
        #1;
        chk("mid reset delay_len", 32'(dl[0]), 24000);
        chk("mid reset len_valid", 32'(lv[0]), 0);
        chk("mid reset tapping", 32'(tp[0]), 0);
        chk("mid reset unit1 delay_len", 32'(dl[1]), 500);
        chk("mid reset unit1 tapping", 32'(tp[1]), 0);
        @(negedge clk);
        nrst = 1'b1;
        begin
            vec_t a, b;
            a = '{0, 0,   1, 0, 24000, 0, 1};
            b = '{0, 600, 1, 0, 600,   1, 1};   // not averaged with pre-reset prev
            run_step(a, 100);
            run_step(b, 101);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
